// File: rtl/linear_dequant_pkg.sv
// rtl/linear_dequant_pkg.sv - shared FP32 constants, types and helpers for the dequantiser
package linear_dequant_pkg;

   localparam int          FP32_EXP_BIAS = 127;
   localparam int          FP32_EXP_MAX  = 255;
   localparam logic [22:0] FP32_QNAN_MAN = 23'h400000;

   typedef struct packed {
      logic        sign;
      logic [7:0]  exp;
      logic [22:0] man;
   } fp32_t;

   // Leading-zero count of a 24-bit word; 24 for an all-zero input.
   function automatic logic [4:0] lzc24(input logic [23:0] v);
      logic [4:0] n;
      logic       found;
      n     = 5'd24;
      found = 1'b0;
      for (int i = 23; i >= 0; i--) begin
         if (!found && v[i]) begin
            n     = 5'(23 - i);
            found = 1'b1;
         end
      end
      return n;
   endfunction

endpackage

// File: rtl/linear_dequant_lane.sv
// rtl/linear_dequant_lane.sv - one lane: offset/abs, normalise, FP32 multiply with RNE and specials
module linear_dequant_lane
   import linear_dequant_pkg::*;
#(
   parameter int IN_W = 8
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic            advance,
   input  logic            mode,
   input  logic [IN_W-1:0] q,
   input  logic [IN_W-1:0] zero_point,
   input  fp32_t           scale,
   output fp32_t           result
);

   localparam logic [7:0] EXP_TOP = 8'(FP32_EXP_BIAS + 23);

   logic signed [IN_W:0] diff;
   logic                 s1_sign_d, s1_sign_q;
   logic [IN_W-1:0]      s1_mag_d, s1_mag_q;

   logic [23:0] mag24;
   logic [4:0]  lz;
   logic        s2_sign_d, s2_sign_q;
   logic        s2_zero_d, s2_zero_q;
   logic [23:0] s2_sig_d, s2_sig_q;
   logic [7:0]  s2_exp_d, s2_exp_q;

   logic [47:0] prod;
   logic        p47, guard, sticky, round_up, carry;
   logic [22:0] mant_raw;
   logic [24:0] rounded;
   logic [10:0] e_sum;
   logic        res_sign;
   fp32_t       res_d, res_q;

   // Max |d| is 2^IN_W - 1, so the magnitude always fits IN_W bits.
   always_comb begin
      diff = mode ? ($signed({q[IN_W-1], q}) - $signed({zero_point[IN_W-1], zero_point}))
                  : $signed({q[IN_W-1], q});
      s1_sign_d = diff[IN_W];
      s1_mag_d  = diff[IN_W] ? IN_W'(-diff) : IN_W'(diff);
   end

   always_comb begin
      mag24     = 24'(s1_mag_q);
      lz        = lzc24(mag24);
      s2_sig_d  = mag24 << lz;
      s2_exp_d  = EXP_TOP - {3'b000, lz};
      s2_zero_d = (s1_mag_q == '0);
      s2_sign_d = s1_sign_q;
   end

   always_comb begin
      prod     = 48'(s2_sig_q) * 48'({1'b1, scale.man});
      p47      = prod[47];
      mant_raw = p47 ? prod[46:24] : prod[45:23];
      guard    = p47 ? prod[23] : prod[22];
      sticky   = p47 ? (|prod[22:0]) : (|prod[21:0]);
      round_up = guard & (sticky | mant_raw[0]);
      rounded  = {2'b01, mant_raw} + {24'd0, round_up};
      carry    = rounded[24];
      e_sum    = {3'b000, s2_exp_q} + {3'b000, scale.exp} + {10'd0, p47} + {10'd0, carry}
                 - 11'(FP32_EXP_BIAS);
      res_sign = s2_sign_q ^ scale.sign;

      res_d.sign = res_sign;
      res_d.exp  = e_sum[7:0];
      res_d.man  = carry ? rounded[23:1] : rounded[22:0];

      if (scale.exp == 8'(FP32_EXP_MAX) && scale.man != '0) begin
         res_d = '{sign: 1'b0, exp: 8'(FP32_EXP_MAX), man: FP32_QNAN_MAN};
      end else if (scale.exp == 8'(FP32_EXP_MAX)) begin
         if (s2_zero_q) res_d = '{sign: 1'b0, exp: 8'(FP32_EXP_MAX), man: FP32_QNAN_MAN};
         else           res_d = '{sign: res_sign, exp: 8'(FP32_EXP_MAX), man: 23'd0};
      end else if (scale.exp == 8'd0 || s2_zero_q) begin
         res_d = '{sign: res_sign, exp: 8'd0, man: 23'd0};
      end else if (!e_sum[10] && e_sum >= 11'(FP32_EXP_MAX)) begin
         res_d = '{sign: res_sign, exp: 8'(FP32_EXP_MAX), man: 23'd0};
      end else if (e_sum[10] || e_sum == 11'd0) begin
         res_d = '{sign: res_sign, exp: 8'd0, man: 23'd0};
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         s1_sign_q <= 1'b0;
         s1_mag_q  <= '0;
         s2_sign_q <= 1'b0;
         s2_zero_q <= 1'b0;
         s2_sig_q  <= '0;
         s2_exp_q  <= '0;
         res_q     <= '0;
      end else if (advance) begin
         s1_sign_q <= s1_sign_d;
         s1_mag_q  <= s1_mag_d;
         s2_sign_q <= s2_sign_d;
         s2_zero_q <= s2_zero_d;
         s2_sig_q  <= s2_sig_d;
         s2_exp_q  <= s2_exp_d;
         res_q     <= res_d;
      end
   end

   assign result = res_q;

endmodule

// File: rtl/linear_dequant_pipe.sv
// rtl/linear_dequant_pipe.sv - LANES-wide 3-stage int-to-FP32 dequantiser with valid/ready
module linear_dequant_pipe
   import linear_dequant_pkg::*;
#(
   parameter int LANES = 8,
   parameter int IN_W  = 8
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  enable,
   input  logic                  mode,
   input  logic                  src_valid,
   output logic                  src_ready,
   input  logic [LANES*IN_W-1:0] src_data,
   input  logic [IN_W-1:0]       zero_point,
   input  logic [22:0]           scale_man,
   input  logic [7:0]            scale_exp,
   input  logic                  scale_sign,
   output logic                  dst_valid,
   input  logic                  dst_ready,
   output logic [LANES*23-1:0]   dst_man,
   output logic [LANES*8-1:0]    dst_exp,
   output logic [LANES-1:0]      dst_sign
);

   logic        advance;
   logic [2:0]  vld_d, vld_q;
   fp32_t       scale_in, scale_s1_q, scale_s2_q;
   fp32_t       lane_res [LANES];

   // Held in reset, the pipe refuses input even though dst_valid is already low.
   assign advance   = enable && rstn && (!vld_q[2] || dst_ready);
   assign src_ready = advance;
   assign dst_valid = vld_q[2];
   assign vld_d     = {vld_q[1:0], src_valid};
   assign scale_in  = '{sign: scale_sign, exp: scale_exp, man: scale_man};

   // The scale travels alongside the lane data so S3 sees the value captured with its beat.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         vld_q      <= '0;
         scale_s1_q <= '0;
         scale_s2_q <= '0;
      end else if (advance) begin
         vld_q      <= vld_d;
         scale_s1_q <= scale_in;
         scale_s2_q <= scale_s1_q;
      end
   end

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      linear_dequant_lane #(
         .IN_W(IN_W)
      ) u_lane (
         .clk       (clk),
         .rstn      (rstn),
         .advance   (advance),
         .mode      (mode),
         .q         (src_data[i*IN_W +: IN_W]),
         .zero_point(zero_point),
         .scale     (scale_s2_q),
         .result    (lane_res[i])
      );
      assign dst_man[i*23 +: 23] = lane_res[i].man;
      assign dst_exp[i*8 +: 8]   = lane_res[i].exp;
      assign dst_sign[i]         = lane_res[i].sign;
   end

endmodule
